// File: rtl/phrase_store.sv
// ============================================================================
// Module   : phrase_store
// Purpose  : NUM_CH x NUM_ROWS phrase entry store with saturating cursor edits,
//            single-level undo and a background clear sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module phrase_store #(
  parameter int NUM_CH    = 4,
  parameter int NUM_ROWS  = 16,
  parameter int NOTE_MAX  = 107,
  parameter int VOL_MAX   = 63,
  parameter int INST_MAX  = 3,
  parameter int BASE_NOTE = 36,
  parameter int BASE_VOL  = 50,
  parameter int BASE_INST = 0,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RW = $clog2(NUM_ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_active_high,
  input  logic                 play_pause,
  input  logic                 sel_valid,
  input  logic [CW-1:0]        sel_ch,
  input  logic [RW-1:0]        sel_row,
  input  logic [1:0]           sel_field,
  input  logic [1:0]           user_edit,
  input  logic                 undo_req,
  input  logic                 clear_req,
  input  logic [RW-1:0]        rd_row,
  output logic [16*NUM_CH-1:0] ch_data,
  output logic [15:0]          sel_data,
  output logic                 edit_done,
  output logic                 undo_valid,
  output logic                 busy
);

  localparam logic [0:0]  S_IDLE      = 1'b0;
  localparam logic [0:0]  S_CLEAR     = 1'b1;
  localparam logic [15:0] c_EMPTY     = 16'hFFFF;
  localparam logic [15:0] c_BASE      = {8'(BASE_NOTE), 6'(BASE_VOL), 2'(BASE_INST)};
  localparam logic [8:0]  c_NOTE_MAX  = 9'(NOTE_MAX);
  localparam logic [8:0]  c_VOL_MAX   = 9'(VOL_MAX);
  localparam logic [8:0]  c_INST_MAX  = 9'(INST_MAX);
  localparam logic [1:0]  c_ED_NONE   = 2'b00;
  localparam logic [1:0]  c_ED_INC    = 2'b01;
  localparam logic [1:0]  c_ED_DEL    = 2'b11;

  logic [15:0]         r_mem [NUM_CH][NUM_ROWS];
  logic [0:0]          r_state;
  logic [RW-1:0]       r_clr_row;
  logic [1:0]          r_edit_prev;
  logic                r_undo_valid;
  logic [CW-1:0]       r_undo_ch;
  logic [RW-1:0]       r_undo_row;
  logic [15:0]         r_undo_val;
  logic                r_edit_done;
  logic [16*NUM_CH-1:0] r_ch_data;
  logic [15:0]         r_sel_data;

  logic                w_ch_ok;
  logic [CW-1:0]       w_ch_idx;
  logic                w_idle;
  logic                w_edit_evt;
  logic                w_clr_acc;
  logic                w_undo_acc;
  logic                w_edit_acc;
  logic                w_up;
  logic [15:0]         w_old;
  logic [15:0]         w_base;
  logic [8:0]          w_note_r;
  logic [8:0]          w_vol_r;
  logic [8:0]          w_inst_r;
  logic [15:0]         w_new;
  logic                w_unused;

  // A non-power-of-two channel count leaves encodings of sel_ch that map to nothing.
  generate
    if (NUM_CH == (1 << CW)) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_part
      assign w_ch_ok = ({1'b0, sel_ch} < (CW+1)'(NUM_CH));
    end
  endgenerate

  // 9-bit step with saturation at 0 and at the field maximum.
  function automatic logic [8:0] f_step(input logic [8:0] v, input logic [8:0] d,
                                        input logic up, input logic [8:0] maxv);
    logic [8:0] s;
    if (up) begin
      s = v + d;
      if (s > maxv) s = maxv;
    end else begin
      s = (v < d) ? 9'd0 : (v - d);
    end
    return s;
  endfunction

  assign w_ch_idx   = w_ch_ok ? sel_ch : '0;
  assign w_idle     = (r_state == S_IDLE);
  assign w_edit_evt = (user_edit != c_ED_NONE) && (r_edit_prev == c_ED_NONE);
  assign w_clr_acc  = clear_req && !play_pause && w_idle;
  assign w_undo_acc = undo_req && !play_pause && w_idle && r_undo_valid && !w_clr_acc;
  assign w_edit_acc = w_edit_evt && !play_pause && sel_valid && w_idle && w_ch_ok
                      && !w_clr_acc && !w_undo_acc;

  assign w_old  = r_mem[w_ch_idx][sel_row];
  assign w_base = (w_old == c_EMPTY) ? c_BASE : w_old;
  assign w_up   = (user_edit == c_ED_INC);

  always_comb begin
    w_note_r = {1'b0, w_base[15:8]};
    w_vol_r  = {3'b000, w_base[7:2]};
    w_inst_r = {7'b0000000, w_base[1:0]};
    case (sel_field)
      2'b00:   w_note_r = f_step({1'b0, w_base[15:8]}, 9'd1, w_up, c_NOTE_MAX);
      2'b01:   w_note_r = f_step({1'b0, w_base[15:8]}, 9'd12, w_up, c_NOTE_MAX);
      2'b10:   w_vol_r  = f_step({3'b000, w_base[7:2]}, 9'd1, w_up, c_VOL_MAX);
      default: w_inst_r = f_step({7'b0000000, w_base[1:0]}, 9'd1, w_up, c_INST_MAX);
    endcase
    if (user_edit == c_ED_DEL) begin
      w_new = c_EMPTY;
    end else begin
      w_new = {w_note_r[7:0], w_vol_r[5:0], w_inst_r[1:0]};
    end
  end

  // Upper bits are always zero after saturation to in-range maxima.
  assign w_unused = ^{w_note_r[8], w_vol_r[8:6], w_inst_r[8:2]};

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          r_mem[c][r] <= c_EMPTY;
        end
      end
      r_state      <= S_IDLE;
      r_clr_row    <= '0;
      r_edit_prev  <= c_ED_NONE;
      r_undo_valid <= 1'b0;
      r_undo_ch    <= '0;
      r_undo_row   <= '0;
      r_undo_val   <= c_EMPTY;
      r_edit_done  <= 1'b0;
      r_ch_data    <= '1;
      r_sel_data   <= c_EMPTY;
    end else begin
      r_edit_prev <= user_edit;
      r_edit_done <= w_edit_acc | w_undo_acc;
      for (int c = 0; c < NUM_CH; c++) begin
        r_ch_data[16*c +: 16] <= r_mem[c][rd_row];
      end
      r_sel_data <= w_ch_ok ? w_old : c_EMPTY;

      if (r_state == S_IDLE) begin
        if (w_clr_acc) begin
          r_state      <= S_CLEAR;
          r_clr_row    <= '0;
          r_undo_valid <= 1'b0;
        end else if (w_undo_acc) begin
          r_mem[r_undo_ch][r_undo_row] <= r_undo_val;
          r_undo_valid                 <= 1'b0;
        end else if (w_edit_acc) begin
          r_mem[w_ch_idx][sel_row] <= w_new;
          r_undo_ch                <= w_ch_idx;
          r_undo_row               <= sel_row;
          r_undo_val               <= w_old;
          r_undo_valid             <= 1'b1;
        end
      end else begin
        // The sweep runs to completion regardless of play_pause.
        for (int c = 0; c < NUM_CH; c++) begin
          r_mem[c][r_clr_row] <= c_EMPTY;
        end
        r_clr_row <= r_clr_row + RW'(1);
        if (r_clr_row == RW'(NUM_ROWS - 1)) begin
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign ch_data    = r_ch_data;
  assign sel_data   = r_sel_data;
  assign edit_done  = r_edit_done;
  assign undo_valid = r_undo_valid;
  assign busy       = (r_state == S_CLEAR);

endmodule

`default_nettype wire

// File: doc/phrase_store.md
# phrase_store

Parametrised successor to the 4×16 phrase register file. It holds `NUM_CH` channels × `NUM_ROWS` rows of 16-bit phrase entries. It applies edge-triggered cursor edits (inc / dec / delete) with saturating per-field arithmetic, and adds a single-level undo and a background clear-sweep state machine. It sits between the UI cursor decoder, which supplies channel/row/field directly, and the playback sequencer, which reads one row of all channels per step.

## Interface
- `NUM_CH`, default 4: number of channels (≥1).
- `NUM_ROWS`, default 16: rows per channel (≥2, power of two).
- `NOTE_MAX`, default 107: highest note (B8).
- `VOL_MAX`, default 63: highest volume.
- `INST_MAX`, default 3: highest instrument.
- `BASE_NOTE` / `BASE_VOL` / `BASE_INST`, defaults 36 / 50 / 0: values seeded into an empty entry on its first edit.
- Derived widths: `CW = max(1, $clog2(NUM_CH))`, `RW = $clog2(NUM_ROWS)`.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst_active_high` in 1: synchronous, active-high reset.
- `play_pause` in 1: 1 = playing; edits, undo and clear requests are ignored while high.
- `sel_valid` in 1: cursor is on an editable entry.
- `sel_ch` in CW: selected channel.
- `sel_row` in RW: selected row.
- `sel_field` in 2: field under the cursor. 00 note, 01 octave, 10 vol, 11 inst.
- `user_edit` in 2: edit code. 00 none, 01 inc, 10 dec, 11 delete. Held level from the keypad.
- `undo_req` in 1: single-cycle pulse requesting undo.
- `clear_req` in 1: single-cycle pulse requesting a clear of every entry.
- `rd_row` in RW: playback row.
- `ch_data` out 16·NUM_CH: entries at `rd_row`; channel k is at bits [16k+15:16k].
- `sel_data` out 16: entry at (`sel_ch`, `sel_row`).
- `edit_done` out 1: pulses when an edit or undo has been written.
- `undo_valid` out 1: an undo record is held.
- `busy` out 1: clear sweep in progress.

## Operation
- Entry format: note [15:8], vol [7:2], inst [1:0]. The value 16'hFFFF means empty.
- Edit edge: `edit_evt` = (`user_edit` ≠ 00) && (`user_edit_prev` == 00). `user_edit_prev` is a register of `user_edit`.
- An edit is accepted when `edit_evt` && !`play_pause` && `sel_valid` && state IDLE && `sel_ch` < NUM_CH.
  - If any condition fails, the edit is dropped, not queued.
- New-value rules:
  - Delete (11) always writes FFFF.
  - If the old entry is FFFF, start from {BASE_NOTE, BASE_VOL, BASE_INST}, then apply the operation.
  - Note: ±1, saturating at 0 and NOTE_MAX.
  - Octave: ±12 on the note, clamped to NOTE_MAX or to 0.
  - Vol: ±1, saturating at 0 and VOL_MAX.
  - Inst: ±1, saturating at 0 and INST_MAX.
  - Unselected fields are preserved.
  - All arithmetic is done 9 bits wide before saturation, so there is no wrap.
- Undo record: an accepted edit stores {ch, row, old value} and sets `undo_valid`.
  - An accepted `undo_req` (paused, IDLE, `undo_valid`) writes the old value back and clears `undo_valid`.
  - An undo is not itself undoable.
  - An `undo_req` with `undo_valid` = 0 is a no-op.
- State machine: IDLE, CLEAR.
  - IDLE → CLEAR on `clear_req` && !`play_pause`. This loads `clr_row` = 0 and clears `undo_valid`.
  - In CLEAR, each cycle writes FFFF to row `clr_row` of every channel, then increments `clr_row`.
  - CLEAR → IDLE after the row NUM_ROWS−1 write.
  - `clear_req` while in CLEAR or while playing is ignored.
  - `play_pause` rising during CLEAR does not abort the sweep.
- Same-cycle priority: clear > undo > edit. The losing requests are dropped.
- Reset: every entry becomes FFFF, state IDLE, `clr_row` = 0, `user_edit_prev` = 00, `undo_valid` = 0.

## Timing
- Writes commit at the clock edge that ends the accept cycle T.
- `edit_done` is high in cycle T+1 only.
- `ch_data` and `sel_data` are registered with 1-cycle latency: the value at cycle N+1 reflects the inputs and array contents at edge N. An edit accepted in T is therefore visible on `sel_data` in T+2.
- `busy` is high for exactly NUM_ROWS cycles, starting the cycle after `clear_req` is accepted.
- Outputs after reset: `ch_data` = all-ones, `sel_data` = FFFF, `edit_done` = 0, `undo_valid` = 0, `busy` = 0.
- Reset asserted mid-sweep: the block is IDLE on the next cycle and the array is fully FFFF.
- A held `user_edit` produces exactly one edit. It must return to 00 before the next edit can be accepted.

## Test plan
- Reset, then paused; ch2/row5 field note, `user_edit` 01 held 4 cycles → one write of 16'h25C8 (note 37, vol 50, inst 0); `edit_done` pulses once; `sel_data` = 25C8.
- Entry 16'h6BC8 (note 107), octave inc → note stays 107 (saturated); then octave dec ×10 → note 0, never wraps.
- Vol at 63 with inc → unchanged. Inst 0 with dec → unchanged. Delete on any entry → FFFF.
- Edit ch1/row3 from 16'h24C8 to 16'h25C8, then `undo_req` → 24C8 restored and `undo_valid` 1→0; a second `undo_req` → no change.
- With NUM_ROWS=16, fill entries, then `clear_req` → `busy` high 16 cycles, all `ch_data` = FFFF afterwards. Raising `play_pause` at sweep cycle 5 does not stop it. Reset at cycle 8 → IDLE, all FFFF.
- `clear_req`, `undo_req` and an edit edge in the same cycle → only the clear occurs and `undo_valid` = 0. With `play_pause` = 1, an edit edge causes no change and no `edit_done`.
